// File: rtl/sys_mem_arb.sv
// -----------------------------------------------------------------------------
// sys_mem_arb
//    Two-port arbiter and access sequencer for the 64x8 system memory.
//    Erase requests win outright; data requests are granted round-robin.
//    Each data grant runs a fixed five-state sequence (S1,S2,S3,ACK,IDLE)
//    that primes the memory word buffer with mode 0 and, for writes, drives
//    two mode-1 edges (rewrite, then merged byte).
//
// Ports
//    clk, rst_n            : clock (rising edge), async active-low reset
//    req0/1, we0/1         : request level and write enable per port
//    adrs0/1, data0/1      : byte address and write data per port
//    ack0/1, out0/1        : one-cycle completion pulse, held read data
//    erase_req, erase_ack  : global erase request / completion pulse
//    busy                  : high whenever the sequencer is not IDLE
//    mem_adrs/mode/data/erase : registered pins to the memory
//    mem_out               : read data from the memory
// -----------------------------------------------------------------------------
module sys_mem_arb #(
   parameter int ADRS_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADRS_W-1:0] adrs0,
   input  logic [ADRS_W-1:0] adrs1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   input  logic              erase_req,
   output logic              erase_ack,
   output logic              busy,
   output logic [ADRS_W-1:0] mem_adrs,
   output logic              mem_mode,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_erase,
   input  logic [DATA_W-1:0] mem_out
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_S1    = 3'd1;
   localparam logic [2:0] ST_S2    = 3'd2;
   localparam logic [2:0] ST_S3    = 3'd3;
   localparam logic [2:0] ST_ACK   = 3'd4;
   localparam logic [2:0] ST_ERASE = 3'd5;
   localparam logic [2:0] ST_EACK  = 3'd6;

   logic [2:0]        state_q,     state_d;
   logic              rr_q,        rr_d;
   logic              port_q,      port_d;
   logic              we_q,        we_d;
   logic [ADRS_W-1:0] mem_adrs_q,  mem_adrs_d;
   logic              mem_mode_q,  mem_mode_d;
   logic [DATA_W-1:0] mem_data_q,  mem_data_d;
   logic              mem_erase_q, mem_erase_d;
   logic              ack0_q,      ack0_d;
   logic              ack1_q,      ack1_d;
   logic              eack_q,      eack_d;
   logic              busy_q,      busy_d;
   logic [DATA_W-1:0] out0_q,      out0_d;
   logic [DATA_W-1:0] out1_q,      out1_d;
   logic              grant_s;

   // Winning port: rr breaks ties, otherwise whichever single port is asking
   always_comb begin
      if (req0 && req1) begin
         grant_s = rr_q;
      end else begin
         grant_s = req1;
      end
   end

   // Sequencer next-state and registered-output next values
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      port_d      = port_q;
      we_d        = we_q;
      mem_adrs_d  = mem_adrs_q;
      mem_mode_d  = mem_mode_q;
      mem_data_d  = mem_data_q;
      mem_erase_d = 1'b0;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      eack_d      = 1'b0;
      out0_d      = out0_q;
      out1_d      = out1_q;

      case (state_q)
         ST_IDLE: begin
            mem_mode_d = 1'b0;
            if (erase_req) begin
               mem_erase_d = 1'b1;
               state_d     = ST_ERASE;
            end else if (req0 || req1) begin
               port_d     = grant_s;
               we_d       = grant_s ? we1 : we0;
               mem_adrs_d = grant_s ? adrs1 : adrs0;
               mem_data_d = grant_s ? data1 : data0;
               rr_d       = ~grant_s;
               state_d    = ST_S1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         // Buffer is primed on the edge leaving S1; writes then raise mode
         ST_S1: begin
            mem_mode_d = we_q;
            state_d    = ST_S2;
         end
         ST_S2: begin
            mem_mode_d = we_q;
            state_d    = ST_S3;
         end
         // Leaving S3: mode back to 0, read data captured, ack raised
         ST_S3: begin
            mem_mode_d = 1'b0;
            if (!we_q) begin
               if (port_q) begin
                  out1_d = mem_out;
               end else begin
                  out0_d = mem_out;
               end
            end else begin
               out0_d = out0_q;
            end
            ack0_d  = ~port_q;
            ack1_d  = port_q;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         ST_ERASE: begin
            eack_d  = 1'b1;
            state_d = ST_EACK;
         end
         ST_EACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            mem_mode_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b0;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         mem_adrs_q  <= '0;
         mem_mode_q  <= 1'b0;
         mem_data_q  <= '0;
         mem_erase_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         eack_q      <= 1'b0;
         busy_q      <= 1'b0;
         out0_q      <= '0;
         out1_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         port_q      <= port_d;
         we_q        <= we_d;
         mem_adrs_q  <= mem_adrs_d;
         mem_mode_q  <= mem_mode_d;
         mem_data_q  <= mem_data_d;
         mem_erase_q <= mem_erase_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         eack_q      <= eack_d;
         busy_q      <= busy_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign out0      = out0_q;
   assign out1      = out1_q;
   assign erase_ack = eack_q;
   assign busy      = busy_q;
   assign mem_adrs  = mem_adrs_q;
   assign mem_mode  = mem_mode_q;
   assign mem_data  = mem_data_q;
   assign mem_erase = mem_erase_q;

endmodule

// File: doc/sys_mem_arb.md
# sys_mem_arb

Two-port arbiter and sequencer for the 64x8 system memory (`sys_mem`). It accepts byte read/write requests from two requesters plus a global erase request. It grants them round-robin (erase has highest priority) and drives the memory's `adrs`/`mode`/`data`/`erase` pins with the multi-cycle sequences the memory requires. It then returns read data and a one-cycle acknowledge to the winner.

## Interface
- `ADRS_W`, default 6: byte address width. Fixed to the memory depth.
- `DATA_W`, default 8: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: request level. Held high until the matching ack; dropped on the edge after ack.
- `we0` / `we1` in 1: 1 = write, 0 = read. Stable while req is high.
- `adrs0` / `adrs1` in ADRS_W: byte address. Stable while req is high.
- `data0` / `data1` in DATA_W: write data. Stable while req is high.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `out0` / `out1` out DATA_W: read data. Valid in the ack cycle and held until that port's next read completes.
- `erase_req` in 1: erase request level. Same handshake as req.
- `erase_ack` out 1: one-cycle erase completion pulse.
- `busy` out 1: high in every state except IDLE.
- `mem_adrs` out ADRS_W: to memory `adrs`. Registered.
- `mem_mode` out 1: to memory `mode`. Registered.
- `mem_data` out DATA_W: to memory `data`. Registered.
- `mem_erase` out 1: to memory `erase`. Registered.
- `mem_out` in DATA_W: from memory `out`.

## Operation
- States: IDLE, S1, S2, S3, ACK, ERASE, EACK.
- Arbitration happens in IDLE only.
  - If `erase_req` is high, go to ERASE.
  - Otherwise, if exactly one `reqN` is high, grant it.
  - If both are high, grant the port named by the round-robin pointer `rr`.
  - After every data grant, `rr` points to the other port. Erase does not touch `rr`.
- On a data grant:
  - Latch the port id and `we`.
  - Drive `mem_adrs`, `mem_data` from the granted port.
  - Drive `mem_mode`=0 (read/prime).
  - Go to S1.
- Read path: S1 -> S2 -> S3, with `mem_mode`=0 throughout.
  - In S3, capture `mem_out` into `outN` and go to ACK.
- Write path:
  - S1: `mem_mode` becomes 1. The memory has just primed its word buffer with the target word.
  - S2: `mem_mode` stays 1.
  - S3: `mem_mode` returns to 0; go to ACK.
  - The memory rewrites the stored word unchanged on the first mode-1 edge and writes the merged byte on the second.
- ACK: pulse `ackN`, then go to IDLE.
- ERASE: `mem_erase`=1 for exactly one cycle, then EACK. EACK pulses `erase_ack`, then goes to IDLE.
- Invariants:
  - `mem_mode`=1 only in S1/S2 of a write.
  - `mem_adrs` never changes while `mem_mode`=1.
  - `mem_mode`=0 whenever `mem_erase`=1.
  - The memory is therefore never written with a stale buffer.
- Requests raised while busy wait. They are never lost provided they are held high.

## Timing
- Reset (async assert, sync release): state IDLE and `rr` = port 0. Every output is 0: `ack0/1`, `out0/1`, `erase_ack`, `busy`, `mem_adrs`, `mem_mode`, `mem_data`, `mem_erase`.
- Let E0 be the edge where IDLE accepts a data request.
  - `mem_adrs`, `mem_mode` and `mem_data` are valid from E0.
  - `ackN` is high in the cycle after E3.
  - The state is back in IDLE at E4.
  - The next accept is possible at E5, so throughput is one op per 5 cycles.
  - Reads and writes have the same latency.
- Erase accepted at E0:
  - `mem_erase` is high E0–E1.
  - `erase_ack` is high in the cycle after E1.
  - The state is in IDLE at E2.
- Simultaneous `erase_req` + `req0` + `req1`: erase first, then the `rr` port, then the other port.
- Reset mid-operation: the sequence aborts with no ack.
  - `mem_mode` and `mem_erase` drop to 0 immediately.
  - A write aborted after the S1 edge may or may not have landed. A write aborted before it has not landed.
- Address wrap-around: none. Any 6-bit address is legal.

## Test plan
- **Reset:** hold `rst_n`=0 mid-write, release. All outputs are 0, no ack is issued, and the memory word at the target address is unchanged if reset occurred before the S1 edge.
- **Single write then read:** port 0 writes 0xA5 to address 0x07, then reads 0x07. `ack0` appears 4 cycles after each accept and `out0`=0xA5. Bytes 0x04–0x06 are unchanged (pre-written 0x11, 0x22, 0x33).
- **Contention:** `req0` and `req1` are raised in the same cycle after reset, both as reads. Port 0 is served first and port 1 second. Raise both again: port 0 is served first again, because `rr` returned to port 0.
- **Back-to-back round-robin:** both ports hold continuous writes to addresses 0x00–0x03. Grants alternate 0,1,0,1. Ack spacing is 5 cycles, and the final memory contents match the issued data.
- **Erase priority:** `erase_req`, `req0` and `req1` are raised together. The erase completes first (`erase_ack` 2 cycles after accept), then both data ops. A read of any address afterwards returns 0x00.
- **Mode invariant:** monitor every cycle.
  - `mem_mode`=1 never occurs outside write S1/S2.
  - `mem_adrs` is stable whenever `mem_mode`=1.
  - `mem_erase` and `mem_mode` are never both high.
